// File: rtl/canny_window_feeder_if.sv
// ---------------------------------------------------------------------------
// canny_window_feeder_if
//
// Bundles the pixel-input handshake and the 3x3 window-output handshake of
// the Canny window feeder into a single interface.
//
// Signals
//   pix_valid  : source has a pixel on mag_in/dir_in
//   pix_ready  : feeder accepts the pixel this cycle
//   mag_in     : 8-bit gradient magnitude
//   dir_in     : 8-bit quantised gradient direction
//   win_valid  : window outputs hold a valid interior window
//   win_ready  : consumer takes the window this cycle
//   win_a      : north row {NW, N, NE}
//   win_b      : centre row {W, C, E}
//   win_c      : south row {SW, S, SE}
//   win_dir_b  : centre-row directions {W, C, E}
//   win_row    : row of the window centre
//   win_col    : column of the window centre
//   frame_done : one-cycle pulse after the last pixel of a frame is taken
//
// Modports
//   master : pixel source / window consumer side
//   slave  : the feeder itself
// ---------------------------------------------------------------------------
interface canny_window_feeder_if #(
  parameter int CW = 10,
  parameter int RW = 10
);

  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    mag_in;
  logic [7:0]    dir_in;
  logic          win_valid;
  logic          win_ready;
  logic [23:0]   win_a;
  logic [23:0]   win_b;
  logic [23:0]   win_c;
  logic [23:0]   win_dir_b;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;

  // The environment drives pixels in and decides when windows are consumed.
  modport master (
    output pix_valid, mag_in, dir_in, win_ready,
    input  pix_ready, win_valid, win_a, win_b, win_c, win_dir_b,
           win_row, win_col, frame_done
  );

  // The feeder consumes pixels and produces windows.
  modport slave (
    input  pix_valid, mag_in, dir_in, win_ready,
    output pix_ready, win_valid, win_a, win_b, win_c, win_dir_b,
           win_row, win_col, frame_done
  );

endinterface

// File: rtl/canny_window_feeder.sv
// ---------------------------------------------------------------------------
// canny_window_feeder
//
// Line-buffer window generator in front of the Canny non-maximum-suppression
// stage. A raster-order stream of magnitude/direction bytes is written into
// two magnitude line buffers (rows r-2 and r-1) and one direction line
// buffer (row r-1). Three 24-bit shift registers slide across the image and
// present a 3x3 magnitude window plus the centre-row directions for every
// interior pixel. Border pixels never produce a window.
//
// Parameters
//   IMG_W, IMG_H : image size in pixels (each >= 3)
//   CW, RW       : column / row counter widths
//
// Ports
//   clk   : clock, everything on the rising edge
//   reset : synchronous, active-high
//   bus   : canny_window_feeder_if slave modport carrying the pixel input
//           handshake, the window output handshake and frame_done
// ---------------------------------------------------------------------------
module canny_window_feeder #(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 1024,
  parameter int CW    = 10,
  parameter int RW    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  canny_window_feeder_if.slave bus
);

  localparam int            AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0]    lb0    [IMG_W];
  logic [7:0]    lb1    [IMG_W];
  logic [7:0]    dirBuf [IMG_W];

  logic [AW-1:0] addr;
  logic [7:0]    lb0Rd;
  logic [7:0]    lb1Rd;
  logic [7:0]    dirRd;

  logic          pixReady;
  logic          accept;
  logic          memWrite;
  logic          lastCol;
  logic          lastRow;
  logic          interior;

  logic          winValid;
  logic [23:0]   winA;
  logic [23:0]   winB;
  logic [23:0]   winC;
  logic [23:0]   winDirB;
  logic [RW-1:0] winRow;
  logic [CW-1:0] winCol;
  logic          frameDone;

  // A new pixel can enter whenever the window register is free or is being
  // emptied this very cycle, so a fully streaming consumer sees one window
  // per accepted pixel with no bubble.
  assign pixReady = !winValid || bus.win_ready;
  assign accept   = bus.pix_valid && pixReady;
  assign memWrite = accept && !reset;

  // The line buffers are indexed directly by the column of the incoming
  // pixel; the same address is read and then overwritten in one cycle.
  assign addr    = col[AW-1:0];
  assign lb0Rd   = lb0[addr];
  assign lb1Rd   = lb1[addr];
  assign dirRd   = dirBuf[addr];

  assign lastCol  = (col == LAST_COL);
  assign lastRow  = (row == LAST_ROW);
  // The window centre trails the incoming pixel by one row and one column,
  // so only pixels at r>=2, c>=2 complete a window whose centre is interior.
  // This also hides whatever an earlier frame left in the line buffers.
  assign interior = (row >= RW'(2)) && (col >= CW'(2));

  // Line buffer storage. Each accepted pixel pushes the column's history up
  // by one row: the old r-1 value moves into the r-2 buffer and the new
  // pixel becomes the r-1 value. There is deliberately no reset here so the
  // block maps onto plain RAM; stale contents are masked by the interior
  // rule above.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      lb0[addr]    <= lb1Rd;
      lb1[addr]    <= bus.mag_in;
      dirBuf[addr] <= bus.dir_in;
    end
  end

  // Raster position of the pixel currently being offered. Both counters
  // wrap together at the last pixel so back-to-back frames need no idle
  // cycle in between.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (lastCol) begin
        col <= '0;
        row <= lastRow ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // End-of-frame marker, raised for exactly one cycle after the final
  // pixel of the frame has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      frameDone <= 1'b0;
    end else begin
      frameDone <= accept && lastCol && lastRow;
    end
  end

  // Window shift registers. Every accepted pixel slides all three rows one
  // column to the left, pulling the south pixel from the input and the
  // centre/north pixels from the line buffers. The window is only flagged
  // valid when the shift completed an interior neighbourhood; otherwise the
  // registers keep sliding silently so they are primed at column 2.
  // Without an accept, a consumer taking the window simply empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      winValid <= 1'b0;
      winA     <= '0;
      winB     <= '0;
      winC     <= '0;
      winDirB  <= '0;
      winRow   <= '0;
      winCol   <= '0;
    end else if (accept) begin
      winC     <= {winC[15:0], bus.mag_in};
      winB     <= {winB[15:0], lb1Rd};
      winA     <= {winA[15:0], lb0Rd};
      winDirB  <= {winDirB[15:0], dirRd};
      winValid <= interior;
      if (interior) begin
        winRow <= row - RW'(1);
        winCol <= col - CW'(1);
      end
    end else if (bus.win_ready) begin
      winValid <= 1'b0;
    end
  end

  // Drive the interface from the internal registers.
  assign bus.pix_ready  = pixReady;
  assign bus.win_valid  = winValid;
  assign bus.win_a      = winA;
  assign bus.win_b      = winB;
  assign bus.win_c      = winC;
  assign bus.win_dir_b  = winDirB;
  assign bus.win_row    = winRow;
  assign bus.win_col    = winCol;
  assign bus.frame_done = frameDone;

endmodule

// File: tb/tb_canny_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_canny_window_feeder
//
// Directed bench for canny_window_feeder. A 5x4 instance covers reset,
// first-window latency, frame_done, back-to-back frames, mid-frame reset and
// backpressure. An 8x8 instance is driven with random valid/ready gaps.
// Window contents are predicted from the pixel formula used to drive the
// image, never from the DUT.
// ---------------------------------------------------------------------------
module tb_canny_window_feeder;

  localparam int SW = 5;
  localparam int SH = 4;
  localparam int LW = 8;
  localparam int LH = 8;

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  canny_window_feeder_if #(.CW(10), .RW(10)) busS ();
  canny_window_feeder_if #(.CW(10), .RW(10)) busL ();

  canny_window_feeder #(.IMG_W(SW), .IMG_H(SH), .CW(10), .RW(10)) dutS (
    .clk   (clk),
    .reset (reset),
    .bus   (busS)
  );

  canny_window_feeder #(.IMG_W(LW), .IMG_H(LH), .CW(10), .RW(10)) dutL (
    .clk   (clk),
    .reset (reset),
    .bus   (busL)
  );

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Image model: odd frames are offset by 100 so stale rows are detectable.
  function automatic logic [7:0] magOf(input int f, input int r, input int c);
    return 8'((10 * r + c + (f % 2) * 100) & 255);
  endfunction

  function automatic logic [7:0] dirOf(input int r, input int c);
    return 8'((r * 64 + c) & 255);
  endfunction

  function automatic logic [23:0] rowOf(input int f, input int r, input int c);
    return {magOf(f, r, c - 1), magOf(f, r, c), magOf(f, r, c + 1)};
  endfunction

  task automatic checkWindow(input string tag, input int f, input int r,
                             input int c, input logic [23:0] a,
                             input logic [23:0] b, input logic [23:0] cc,
                             input logic [23:0] d, input logic [9:0] wr,
                             input logic [9:0] wc);
    checkOutput({tag, ".row"}, 32'(wr), 32'(r));
    checkOutput({tag, ".col"}, 32'(wc), 32'(c));
    checkOutput({tag, ".a"}, 32'(a), 32'(rowOf(f, r - 1, c)));
    checkOutput({tag, ".b"}, 32'(b), 32'(rowOf(f, r, c)));
    checkOutput({tag, ".c"}, 32'(cc), 32'(rowOf(f, r + 1, c)));
    checkOutput({tag, ".dir"}, 32'(d),
                32'({dirOf(r, c - 1), dirOf(r, c), dirOf(r, c + 1)}));
  endtask

  // Small-instance monitor: every consumed window must be the next interior
  // centre in raster order with contents matching the model.
  int expRS = 1, expCS = 1, monFS = 0, winCountS = 0, fdCountS = 0;
  always @(negedge clk) begin
    if (reset) begin
      expRS = 1;
      expCS = 1;
      monFS = 0;
    end else begin
      if (busS.frame_done) fdCountS++;
      if (busS.win_valid && busS.win_ready) begin
        checkWindow("winS", monFS, expRS, expCS, busS.win_a, busS.win_b,
                    busS.win_c, busS.win_dir_b, busS.win_row, busS.win_col);
        winCountS++;
        expCS++;
        if (expCS == SW - 1) begin
          expCS = 1;
          expRS++;
          if (expRS == SH - 1) begin
            expRS = 1;
            monFS++;
          end
        end
      end
    end
  end

  // Large-instance monitor, same idea for the 8x8 random run.
  int expRL = 1, expCL = 1, winCountL = 0, fdCountL = 0;
  always @(negedge clk) begin
    if (reset) begin
      expRL = 1;
      expCL = 1;
    end else begin
      if (busL.frame_done) fdCountL++;
      if (busL.win_valid && busL.win_ready) begin
        checkWindow("winL", 0, expRL, expCL, busL.win_a, busL.win_b,
                    busL.win_c, busL.win_dir_b, busL.win_row, busL.win_col);
        winCountL++;
        expCL++;
        if (expCL == LW - 1) begin
          expCL = 1;
          expRL++;
          if (expRL == LH - 1) expRL = 1;
        end
      end
    end
  end

  // Small-instance driver position.
  int dRS = 0, dCS = 0, dFS = 0;

  task automatic advanceS();
    dCS++;
    if (dCS == SW) begin
      dCS = 0;
      dRS++;
      if (dRS == SH) begin
        dRS = 0;
        dFS++;
      end
    end
  endtask

  // Offers pixels continuously until nAcc of them are accepted. Called and
  // returns just after a rising edge.
  task automatic applyStimulus(input int nAcc);
    int  got = 0;
    int  cyc = 0;
    bit  acc;
    while (got < nAcc && cyc < 200) begin
      busS.pix_valid = 1'b1;
      busS.mag_in    = magOf(dFS, dRS, dCS);
      busS.dir_in    = dirOf(dRS, dCS);
      @(negedge clk);
      acc = busS.pix_valid && busS.pix_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        advanceS();
        got++;
      end
      cyc++;
    end
    busS.pix_valid = 1'b0;
    if (got < nAcc) checkOutput("acceptTimeout", 32'(got), 32'(nAcc));
  endtask

  // Stop runaway simulations with a visible failure.
  initial begin
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  dRL = 0, dCL = 0, gotL = 0, cycL = 0;
    bit  accL;

    reset          = 1'b1;
    busS.pix_valid = 1'b0;
    busS.win_ready = 1'b1;
    busS.mag_in    = '0;
    busS.dir_in    = '0;
    busL.pix_valid = 1'b0;
    busL.win_ready = 1'b1;
    busL.mag_in    = '0;
    busL.dir_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rstValid", 32'(busS.win_valid), 0);
    checkOutput("rstReady", 32'(busS.pix_ready), 1);
    checkOutput("rstWinA", 32'(busS.win_a), 0);
    checkOutput("rstRow", 32'(busS.win_row), 0);
    checkOutput("rstDone", 32'(busS.frame_done), 0);
    @(posedge clk);
    #1;

    $display("[TB] first frame, streaming");
    applyStimulus(12);
    checkOutput("noWinBefore22", 32'(busS.win_valid), 0);
    applyStimulus(1);
    checkOutput("firstValid", 32'(busS.win_valid), 1);
    checkOutput("firstRow", 32'(busS.win_row), 1);
    checkOutput("firstCol", 32'(busS.win_col), 1);
    checkOutput("firstA", 32'(busS.win_a), 32'h000102);
    checkOutput("firstB", 32'(busS.win_b), 32'h0A0B0C);
    checkOutput("firstC", 32'(busS.win_c), 32'h141516);
    checkOutput("firstDir", 32'(busS.win_dir_b), 32'h404142);
    applyStimulus(7);
    checkOutput("frameDonePulse", 32'(busS.frame_done), 1);

    $display("[TB] back-to-back second frame");
    applyStimulus(20);
    repeat (2) @(negedge clk);
    checkOutput("winsAfter2", 32'(winCountS), 12);
    checkOutput("doneAfter2", 32'(fdCountS), 2);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    applyStimulus(12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dRS = 0;
    dCS = 0;
    dFS = 0;
    checkOutput("midRstValid", 32'(busS.win_valid), 0);
    checkOutput("midRstReady", 32'(busS.pix_ready), 1);
    checkOutput("midRstA", 32'(busS.win_a), 0);
    checkOutput("midRstB", 32'(busS.win_b), 0);
    checkOutput("midRstC", 32'(busS.win_c), 0);
    checkOutput("midRstDir", 32'(busS.win_dir_b), 0);
    checkOutput("midRstCol", 32'(busS.win_col), 0);

    $display("[TB] fresh frame with backpressure");
    applyStimulus(13);
    checkOutput("freshValid", 32'(busS.win_valid), 1);
    checkOutput("freshRow", 32'(busS.win_row), 1);
    checkOutput("freshCol", 32'(busS.win_col), 1);
    busS.win_ready = 1'b0;
    busS.pix_valid = 1'b1;
    busS.mag_in    = magOf(dFS, dRS, dCS);
    busS.dir_in    = dirOf(dRS, dCS);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stallReady", 32'(busS.pix_ready), 0);
    end
    checkOutput("stallValid", 32'(busS.win_valid), 1);
    checkOutput("stallA", 32'(busS.win_a), 32'h000102);
    checkOutput("stallB", 32'(busS.win_b), 32'h0A0B0C);
    checkOutput("stallC", 32'(busS.win_c), 32'h141516);
    checkOutput("stallCol", 32'(busS.win_col), 1);
    @(posedge clk);
    #1;
    busS.win_ready = 1'b1;
    @(negedge clk);
    checkOutput("releaseReady", 32'(busS.pix_ready), 1);
    @(posedge clk);
    #1;
    busS.win_ready = 1'b0;
    advanceS();
    busS.mag_in = magOf(dFS, dRS, dCS);
    busS.dir_in = dirOf(dRS, dCS);
    @(negedge clk);
    checkOutput("oneMoreValid", 32'(busS.win_valid), 1);
    checkOutput("oneMoreRow", 32'(busS.win_row), 1);
    checkOutput("oneMoreCol", 32'(busS.win_col), 2);
    checkOutput("oneMoreReady", 32'(busS.pix_ready), 0);
    checkOutput("oneMoreA", 32'(busS.win_a), 32'h010203);
    checkOutput("oneMoreB", 32'(busS.win_b), 32'h0B0C0D);
    @(posedge clk);
    #1;
    busS.win_ready = 1'b1;
    applyStimulus(6);
    repeat (2) @(negedge clk);
    checkOutput("winsAfterStall", 32'(winCountS), 18);
    checkOutput("doneAfterStall", 32'(fdCountS), 3);
    @(posedge clk);
    #1;

    $display("[TB] random gaps on 8x8");
    while (gotL < LW * LH && cycL < 3000) begin
      busL.pix_valid = ($urandom_range(0, 3) != 0);
      busL.win_ready = ($urandom_range(0, 3) != 0);
      busL.mag_in    = magOf(0, dRL, dCL);
      busL.dir_in    = dirOf(dRL, dCL);
      @(negedge clk);
      accL = busL.pix_valid && busL.pix_ready;
      @(posedge clk);
      #1;
      if (accL) begin
        dCL++;
        if (dCL == LW) begin
          dCL = 0;
          dRL++;
        end
        gotL++;
      end
      cycL++;
    end
    busL.pix_valid = 1'b0;
    busL.win_ready = 1'b1;
    checkOutput("acceptsL", 32'(gotL), 32'(LW * LH));
    repeat (3) @(negedge clk);
    checkOutput("winsL", 32'(winCountL), 36);
    checkOutput("doneL", 32'(fdCountL), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canny_window_feeder.md
# canny_window_feeder

Line-buffer window generator that feeds the Canny non-maximum-suppression stage. It accepts a raster-order stream of gradient magnitude and quantised direction bytes and maintains two magnitude line buffers plus one direction line buffer. For each interior pixel it presents a 3x3 magnitude window as three packed 24-bit rows (A = north, B = centre, C = south) and the centre row of directions. Output uses a valid/ready handshake with backpressure to the pixel source.

## Interface
- IMG_W, 1024: image width in pixels (≥3)
- IMG_H, 1024: image height in pixels (≥3)
- CW, 10: column counter width, ≥ clog2(IMG_W)
- RW, 10: row counter width, ≥ clog2(IMG_H)

- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- pix_valid  in  1  mag_in/dir_in hold a pixel
- pix_ready  out  1  block accepts pixel this cycle
- mag_in  in  8  gradient magnitude
- dir_in  in  8  direction code (255 NW, 192 N, 128 NE, other E)
- win_valid  out  1  window outputs hold a valid interior window
- win_ready  in  1  consumer takes window this cycle
- win_a  out  24  north row {NW, N, NE} in [23:16],[15:8],[7:0]
- win_b  out  24  centre row {W, centre, E}
- win_c  out  24  south row {SW, S, SE}
- win_dir_b  out  24  centre-row directions, centre in [15:8]
- win_row  out  RW  row of window centre
- win_col  out  CW  column of window centre
- frame_done  out  1  one-cycle pulse after last pixel of a frame is accepted

## Operation
- Accept: a pixel is accepted when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (combinational). Nothing advances without acceptance.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position (r,c) of the accepted pixel.
  - col wraps to 0 and row increments at IMG_W-1.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done pulses the next cycle.
- Line buffers lb0 (row r-2) and lb1 (row r-1), IMG_W x 8 each; dirbuf (row r-1 directions), IMG_W x 8.
- On accept at (r,c), all updates happen in the same edge:
  - win_c <= {win_c[15:0], mag_in}
  - win_b <= {win_b[15:0], lb1[c]}
  - win_a <= {win_a[15:0], lb0[c]}
  - win_dir_b <= {win_dir_b[15:0], dirbuf[c]}
  - lb0[c] <= lb1[c]; lb1[c] <= mag_in; dirbuf[c] <= dir_in
- After that edge the window centre is (r-1, c-1).
- win_valid:
  - Set on an accept with r≥2 and c≥2; win_row <= r-1, win_col <= c-1.
  - Cleared on an accept that does not qualify, or when win_ready is high and there is no accept.
  - Windows straddling a row boundary (c<2) and the first two rows of each frame are never presented.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) produce no window. Downstream treats them as 0.
- Line buffers are not cleared between frames; the r≥2 rule masks stale data.

## Timing
- Latency: accept at (r,c) to win_valid on the next cycle, carrying centre (r-1,c-1).
- Throughput: one pixel per cycle while win_ready stays high.
- Stall: while win_valid && !win_ready:
  - pix_ready=0.
  - All window outputs, win_row/win_col and counters are held stable.
- Simultaneous win_ready and an accept: the consumer takes the old window and the new window loads on the same edge.
- Windows per frame: exactly (IMG_H-2)*(IMG_W-2).
- Reset (any time, including mid-frame):
  - Next edge: col=row=0, win_valid=0, frame_done=0.
  - win_a/win_b/win_c/win_dir_b = 0, win_row/win_col = 0.
  - pix_ready is 1 on the first cycle after reset.
  - Line buffer memory is left unchanged.
- Line buffers are a read-before-write per address in the accept cycle. Single-port RAM inference is permitted since the same address is read and written.

## Test plan
- IMG_W=5, IMG_H=4, win_ready=1, mag=10*r+c, dir=0x80, continuous pix_valid:
  - 6 windows, first one cycle after accepting (2,2).
  - First window: win_a=0x000102, win_b=0x0A0B0C, win_c=0x141516, win_row=1, win_col=1.
  - frame_done pulses once, after the 20th accept.
- Same image, win_ready held 0 after the first window:
  - pix_ready drops and outputs stay 0x000102/0x0A0B0C/0x141516.
  - Releasing win_ready for one cycle accepts exactly one more pixel; the next window has win_col=2.
- dir_in=row*64+col with IMG_W=5: window centre (1,1) gives win_dir_b = {dir(1,0), dir(1,1), dir(1,2)} = 0x404142.
- Back-to-back frames with no idle cycle: the second frame yields 6 windows; none is presented from the first two rows, so no stale data is seen.
- Assert reset after 12 accepts, then a fresh frame:
  - win_valid=0 on the cycle after reset.
  - First new window again centres at (1,1) with correct values.
- Random pix_valid and win_ready gaps on IMG_W=IMG_H=8 against a reference model: 36 windows, all bit-exact and in order, no drops or duplicates.
